mem_port_arbiter: RTL

Sits between the L1 instruction cache (port 0), the L1 data cache (port 1) and the single main-memory port. It grants the memory to one cache at a time with round-robin fairness. For the granted cache it sequences one line-fill transaction: an address phase, then WORDS_PER_LINE indexed data beats, then a completion pulse. The arbiter checks beat order, forwards in-order beats to the granted cache only, and holds the grant until the full line has been delivered.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-side request/response wires and the main-memory port
// that the arbiter sits between. "slave" is the arbiter's view, "master"
// is the view of the caches and the memory model driving it.
interface mem_port_arbiter_if #(
  parameter int BEAT_W = 3
);
  // Cache request side
  logic              VALID0;
  logic              VALID1;
  logic [31:0]       ADDR0;
  logic [31:0]       ADDR1;
  // Cache response side
  logic              GNT0;
  logic              GNT1;
  logic              RVALID0;
  logic              RVALID1;
  logic [31:0]       RDATA0;
  logic [31:0]       RDATA1;
  logic [BEAT_W-1:0] RBEAT0;
  logic [BEAT_W-1:0] RBEAT1;
  logic              DONE0;
  logic              DONE1;
  // Main-memory port
  logic              MEM_VALID;
  logic [31:0]       MEM_ADDR;
  logic              MEM_READY;
  logic              MEM_DVALID;
  logic [31:0]       MEM_DATA;
  logic [BEAT_W-1:0] MEM_BEAT;
  // Status
  logic              ERR;

  modport slave (
    input  VALID0, VALID1, ADDR0, ADDR1,
    input  MEM_READY, MEM_DVALID, MEM_DATA, MEM_BEAT,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1,
    output RBEAT0, RBEAT1, DONE0, DONE1,
    output MEM_VALID, MEM_ADDR, ERR
  );

  modport master (
    output VALID0, VALID1, ADDR0, ADDR1,
    output MEM_READY, MEM_DVALID, MEM_DATA, MEM_BEAT,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1,
    input  RBEAT0, RBEAT1, DONE0, DONE1,
    input  MEM_VALID, MEM_ADDR, ERR
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving the I-cache (port 0) or D-cache (port 1)
// exclusive use of main memory for one line fill: address phase, then
// WORDS_PER_LINE in-order beats forwarded to the owner, then a DONE pulse.
// Out-of-order beats are dropped and latch a sticky ERR.
module mem_port_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int BEAT_W         = 3
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [31:0]       LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e                  state_q,     state_d;
  logic                    owner_q,     owner_d;     // port holding the grant
  logic                    prio_q,      prio_d;      // port favoured on a tie
  logic [BEAT_W-1:0]       cnt_q,       cnt_d;       // next expected beat index
  logic [1:0]              gnt_q,       gnt_d;
  logic [1:0]              rvalid_q,    rvalid_d;
  logic [1:0]              done_q,      done_d;
  logic [1:0][31:0]        rdata_q,     rdata_d;
  logic [1:0][BEAT_W-1:0]  rbeat_q,     rbeat_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [31:0]             mem_addr_q,  mem_addr_d;
  logic                    err_q,       err_d;
  logic                    winner_s;

  // Next-state and next-output computation for the fill sequencer
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rvalid_d    = 2'b00;
    done_d      = 2'b00;
    rdata_d     = '0;
    rbeat_d     = '0;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    err_d       = err_q;
    winner_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grant from the previous fill lapses unless re-granted below
        gnt_d = 2'b00;
        if (bus.VALID0 || bus.VALID1) begin
          if (bus.VALID0 && bus.VALID1) begin
            winner_s = prio_q;
          end else begin
            winner_s = bus.VALID1;
          end
          owner_d           = winner_s;
          cnt_d             = '0;
          gnt_d[winner_s]   = 1'b1;
          mem_valid_d       = 1'b1;
          mem_addr_d        = (winner_s ? bus.ADDR1 : bus.ADDR0) & ~LINE_MASK;
          state_d           = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (bus.MEM_READY) begin
          mem_valid_d = 1'b0;
          state_d     = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end

      ST_DATA: begin
        if (bus.MEM_DVALID) begin
          if (bus.MEM_BEAT == cnt_q) begin
            rvalid_d[owner_q] = 1'b1;
            rdata_d[owner_q]  = bus.MEM_DATA;
            rbeat_d[owner_q]  = bus.MEM_BEAT;
            cnt_d             = cnt_q + BEAT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              // Last word: pulse DONE, keep GNT this cycle, hand priority over
              done_d[owner_q] = 1'b1;
              prio_d          = ~owner_q;
              state_d         = ST_IDLE;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 2'b00;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      done_q      <= 2'b00;
      rdata_q     <= '0;
      rbeat_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      rbeat_q     <= rbeat_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
    end
  end

  assign bus.GNT0      = gnt_q[0];
  assign bus.GNT1      = gnt_q[1];
  assign bus.RVALID0   = rvalid_q[0];
  assign bus.RVALID1   = rvalid_q[1];
  assign bus.RDATA0    = rdata_q[0];
  assign bus.RDATA1    = rdata_q[1];
  assign bus.RBEAT0    = rbeat_q[0];
  assign bus.RBEAT1    = rbeat_q[1];
  assign bus.DONE0     = done_q[0];
  assign bus.DONE1     = done_q[1];
  assign bus.MEM_VALID = mem_valid_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.ERR       = err_q;

endmodule
